// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and default width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam int WIDTH_DEFAULT = 4;

endpackage : serial_subtractor_pkg

// File: rtl/full_subtractor.sv
// One-bit full subtractor: d = x - y - bin, with borrow out.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bin,
  output logic d,
  output logic bout
);

  assign d    = x ^ y ^ bin;
  assign bout = (~x & y) | (~(x ^ y) & bin);

endmodule : full_subtractor

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor, LSB first, one bit per clock, start/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_sr_reg, b_sr_reg, r_sr_reg;
  logic [WIDTH-1:0] diff_reg;
  logic             borrow_out_reg;
  logic             brw_reg;
  logic [CW-1:0]    cnt_reg;

  logic             bit_d, bit_bout;
  logic             accept, last_bit;
  logic [WIDTH-1:0] r_sr_next;

  full_subtractor u_fs (
    .x    (a_sr_reg[0]),
    .y    (b_sr_reg[0]),
    .bin  (brw_reg),
    .d    (bit_d),
    .bout (bit_bout)
  );

  assign accept    = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
  assign last_bit  = (state_reg == ST_SHIFT) && (cnt_reg == CW'(WIDTH - 1));
  assign r_sr_next = {bit_d, r_sr_reg[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_SHIFT;
      ST_SHIFT: if (last_bit) state_next = ST_DONE;
      ST_DONE:  state_next = start ? ST_SHIFT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_reg == ST_SHIFT);
    done = (state_reg == ST_DONE);
  end

  // Datapath: operand capture, serial shift, and result hold registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sr_reg       <= '0;
      b_sr_reg       <= '0;
      r_sr_reg       <= '0;
      brw_reg        <= 1'b0;
      cnt_reg        <= '0;
      diff_reg       <= '0;
      borrow_out_reg <= 1'b0;
    end else if (accept) begin
      a_sr_reg <= a;
      b_sr_reg <= b;
      brw_reg  <= borrow_in;
      cnt_reg  <= '0;
    end else if (state_reg == ST_SHIFT) begin
      a_sr_reg <= {1'b0, a_sr_reg[WIDTH-1:1]};
      b_sr_reg <= {1'b0, b_sr_reg[WIDTH-1:1]};
      r_sr_reg <= r_sr_next;
      brw_reg  <= bit_bout;
      if (last_bit) begin
        // Counter parks at zero rather than wrapping past WIDTH-1.
        cnt_reg        <= '0;
        diff_reg       <= r_sr_next;
        borrow_out_reg <= bit_bout;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
  end

  assign diff       = diff_reg;
  assign borrow_out = borrow_out_reg;

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             borrow_in;
  logic             busy, done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  int checks = 0;
  int errors = 0;

  serial_subtractor #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a          (a),
    .b          (b),
    .borrow_in  (borrow_in),
    .busy       (busy),
    .done       (done),
    .diff       (diff),
    .borrow_out (borrow_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference: plain integer subtraction, result mod 2^WIDTH, borrow iff negative.
  function automatic logic [WIDTH:0] ref_sub(input int av, input int bv, input int bi);
    int r;
    r = av - bv - bi;
    return {(r < 0) ? 1'b1 : 1'b0, WIDTH'(r & ((1 << WIDTH) - 1))};
  endfunction

  // Present operands with start=1 now; return #1 after the accept edge with start low.
  task automatic start_now(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic bi);
    a = av; b = bv; borrow_in = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); borrow_in = 1'($urandom);
  endtask

  task automatic wait_done(output int busy_cycles, output bit ok, output bit stable);
    logic [WIDTH-1:0] d0;
    logic             b0;
    d0 = diff; b0 = borrow_out;
    busy_cycles = 0; ok = 1'b0; stable = 1'b1;
    for (int n = 0; n < 20; n++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      if (busy) busy_cycles++;
      if (diff !== d0 || borrow_out !== b0) stable = 1'b0;
      @(posedge clk); #1;
    end
  endtask

  task automatic check_result(input string tag, input logic [WIDTH-1:0] av,
                              input logic [WIDTH-1:0] bv, input logic bi);
    int          bc;
    bit          ok, st;
    logic [WIDTH:0] exp;
    exp = ref_sub(int'(av), int'(bv), int'(bi));
    wait_done(bc, ok, st);
    check({tag, "_done"}, 32'(ok), 32'd1);
    check({tag, "_busy_cycles"}, 32'(bc), 32'(WIDTH));
    check({tag, "_hold"}, 32'(st), 32'd1);
    check({tag, "_diff"}, 32'(diff), 32'(exp[WIDTH-1:0]));
    check({tag, "_borrow"}, 32'(borrow_out), 32'(exp[WIDTH]));
    $display("op %s a=%0d b=%0d bin=%0d -> diff=%0d borrow=%0d", tag, av, bv, bi, diff, borrow_out);
  endtask

  task automatic run_op(input string tag, input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv, input logic bi);
    @(negedge clk);
    start_now(av, bv, bi);
    check_result(tag, av, bv, bi);
  endtask

  initial begin
    rst_n = 1'b1; start = 1'b0; a = '0; b = '0; borrow_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_borrow", 32'(borrow_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    run_op("t2", 4'd3, 4'd6, 1'b0);
    run_op("t3a", 4'd15, 4'd15, 1'b1);
    run_op("t3b", 4'd1, 4'd1, 1'b0);
    run_op("t4a", 4'd0, 4'd0, 1'b1);
    run_op("t4b", 4'd9, 4'd4, 1'b0);

    // start pulsed mid-operation with other operands must be ignored
    @(negedge clk);
    start_now(4'd2, 4'd7, 1'b1);
    @(posedge clk); #1;
    a = 4'd12; b = 4'd1; borrow_in = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("ign_busy", 32'(busy), 32'd1);
    begin
      int bc; bit ok, st; logic [WIDTH:0] exp;
      exp = ref_sub(2, 7, 1);
      wait_done(bc, ok, st);
      check("ign_done", 32'(ok), 32'd1);
      check("ign_diff", 32'(diff), 32'(exp[WIDTH-1:0]));
      check("ign_borrow", 32'(borrow_out), 32'(exp[WIDTH]));
      $display("op ign a=2 b=7 bin=1 -> diff=%0d borrow=%0d", diff, borrow_out);
    end

    // back-to-back: start asserted during the done cycle
    run_op("b2b1", 4'd5, 4'd11, 1'b0);
    start_now(4'd14, 4'd3, 1'b1);
    check("b2b_nogap_busy", 32'(busy), 32'd1);
    check("b2b_nogap_done", 32'(done), 32'd0);
    check_result("b2b2", 4'd14, 4'd3, 1'b1);

    // asynchronous reset mid-operation: outputs clear without a clock, no done
    run_op("pre_rst", 4'd3, 4'd6, 1'b0);
    @(negedge clk);
    start_now(4'd8, 4'd1, 1'b0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("arst_busy", 32'(busy), 32'd0);
    check("arst_done", 32'(done), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    check("arst_borrow", 32'(borrow_out), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    begin
      int seen_done;
      seen_done = 0;
      for (int i = 0; i < 6; i++) begin
        @(posedge clk); #1;
        if (done || busy) seen_done++;
      end
      check("arst_aborted", 32'(seen_done), 32'd0);
    end
    run_op("post_rst", 4'd10, 4'd3, 1'b1);

    for (int i = 0; i < 40; i++) begin
      run_op("rand", WIDTH'($urandom), WIDTH'($urandom), 1'($urandom));
    end

    for (int ai = 0; ai < (1 << WIDTH); ai++)
      for (int bi = 0; bi < (1 << WIDTH); bi++)
        for (int ci = 0; ci < 2; ci++)
          run_op("sweep", WIDTH'(ai), WIDTH'(bi), 1'(ci));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_serial_subtractor
